// File: rtl/soc_system_motor_enable_out_pkg.sv
// Shared definitions for the motor-enable output PIO.
//   - Register map addresses (DATA/SET/CLR/CTRL)
//   - CTRL bit indices (KICK, FCLR)
//   - STATUS bit indices (fault, estop_s, wd_cause) and a helper to pack them
package soc_system_motor_enable_out_pkg;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_SET  = 2'd1,
        REG_CLR  = 2'd2,
        REG_CTRL = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_KICK = 0;
    localparam int unsigned CTRL_FCLR = 1;

    localparam int unsigned STAT_FAULT    = 0;
    localparam int unsigned STAT_ESTOP    = 1;
    localparam int unsigned STAT_WD_CAUSE = 2;

    function automatic logic [31:0] status_word(input logic wd_cause,
                                               input logic estop_s,
                                               input logic fault);
        logic [31:0] w;
        w                = '0;
        w[STAT_WD_CAUSE] = wd_cause;
        w[STAT_ESTOP]    = estop_s;
        w[STAT_FAULT]    = fault;
        return w;
    endfunction

endpackage

// File: rtl/soc_system_motor_enable_out_if.sv
// Avalon-MM slave bus bundle for the motor-enable output PIO.
//   address    2-bit word address
//   chipselect slave select
//   write_n    write strobe, active low
//   writedata  32-bit write data
//   readdata   32-bit registered read data
interface soc_system_motor_enable_out_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/soc_system_motor_enable_out_sync2.sv
// soc_system_sync2: two-flop synchroniser for a single asynchronous level.
//   clk      destination clock
//   reset_n  asynchronous active-low reset, both flops clear to 0
//   d        asynchronous input
//   q        synchronised output (2 clk latency)
module soc_system_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_system_motor_enable_out.sv
// soc_system_motor_enable_out: Avalon-MM PIO driving motor-enable/LED outputs.
// A data register with DATA/SET/CLR access feeds out_port, gated off by a
// latched safety fault. The fault is set by the synchronised e-stop line or
// by expiry of a software-kicked watchdog, and cleared via CTRL.fault_clr.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   avs       Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
//   estop_in  raw asynchronous e-stop level, 1 = stop
//   out_port  gated outputs, forced to 0 while fault = 1
//   fault     fault latch state
module soc_system_motor_enable_out
    import soc_system_motor_enable_out_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      TIMEOUT     = 50000000,
    parameter int unsigned      WDOG_W      = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    soc_system_motor_enable_out_if.slave avs,
    input  logic                         estop_in,
    output logic [WIDTH-1:0]             out_port,
    output logic                         fault
);

    localparam logic [WDOG_W-1:0] WD_RELOAD = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WD_ONE    = WDOG_W'(1);

    logic [WIDTH-1:0]  data_reg;
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_cause;
    logic              estop_s;

    reg_addr_e         addr;
    logic              wr;
    logic              kick;
    logic              fclr;
    logic              wd_expire;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    soc_system_sync2 u_estop_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (estop_in),
        .q       (estop_s)
    );

    // Upper writedata bits beyond WIDTH are intentionally ignored.
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        addr      = reg_addr_e'(avs.address);
        wr        = avs.chipselect && !avs.write_n;
        kick      = wr && (addr == REG_CTRL) && avs.writedata[CTRL_KICK];
        fclr      = wr && (addr == REG_CTRL) && avs.writedata[CTRL_FCLR];
        // A kick landing on the final count reloads instead of expiring.
        wd_expire = (wd_cnt == WD_ONE) && !kick;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            unique case (addr)
                REG_DATA: data_reg <= avs.writedata[WIDTH-1:0];
                REG_SET:  data_reg <= data_reg | avs.writedata[WIDTH-1:0];
                REG_CLR:  data_reg <= data_reg & ~avs.writedata[WIDTH-1:0];
                REG_CTRL: data_reg <= data_reg;
            endcase
        end
    end

    // Counter holds at zero until kicked; it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= WD_RELOAD;
        end else if (kick) begin
            wd_cnt <= WD_RELOAD;
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - WD_ONE;
        end
    end

    // Set sources (e-stop, watchdog expiry) outrank fault_clr; a live e-stop
    // also blocks clearing the watchdog cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault    <= 1'b0;
            wd_cause <= 1'b0;
        end else begin
            if (estop_s || wd_expire) begin
                fault <= 1'b1;
            end else if (fclr) begin
                fault <= 1'b0;
            end

            if (wd_expire) begin
                wd_cause <= 1'b1;
            end else if (fclr && !estop_s) begin
                wd_cause <= 1'b0;
            end
        end
    end

    always_comb begin
        out_port = fault ? '0 : data_reg;
    end

    always_comb begin
        rd_mux = '0;
        unique case (addr)
            REG_DATA: rd_mux = 32'(data_reg);
            REG_SET:  rd_mux = status_word(wd_cause, estop_s, fault);
            REG_CLR:  rd_mux = 32'(out_port);
            REG_CTRL: rd_mux = 32'(wd_cnt);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else begin
            avs.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_motor_enable_out.sv
// Directed bench for soc_system_motor_enable_out.
// dut_a uses the default 50M-cycle watchdog (never expires during the run);
// dut_b uses TIMEOUT=16 to exercise watchdog expiry and kick timing.
// All stimulus is applied and all outputs are sampled on the falling edge.
module tb_soc_system_motor_enable_out;

    logic       clk;
    logic       reset_n;
    logic       estop_a;
    logic       estop_b;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       fault_a;
    logic       fault_b;

    int tests_run;
    int tests_failed;

    soc_system_motor_enable_out_if ifa ();
    soc_system_motor_enable_out_if ifb ();

    soc_system_motor_enable_out #(
        .WIDTH       (8),
        .TIMEOUT     (50000000),
        .WDOG_W      (32),
        .RESET_VALUE (8'h00)
    ) dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (ifa),
        .estop_in (estop_a),
        .out_port (out_a),
        .fault    (fault_a)
    );

    soc_system_motor_enable_out #(
        .WIDTH       (8),
        .TIMEOUT     (16),
        .WDOG_W      (8),
        .RESET_VALUE (8'h00)
    ) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (ifb),
        .estop_in (estop_b),
        .out_port (out_b),
        .fault    (fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
        $fatal(1);
    end

    // Tasks are called on a falling edge and return on a falling edge.
    task automatic bus_write(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
        if (sel_b) begin
            ifb.address = a; ifb.writedata = d; ifb.chipselect = 1'b1; ifb.write_n = 1'b0;
        end else begin
            ifa.address = a; ifa.writedata = d; ifa.chipselect = 1'b1; ifa.write_n = 1'b0;
        end
        @(negedge clk);
        ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
        ifb.chipselect = 1'b0; ifb.write_n = 1'b1;
    endtask

    task automatic bus_read(input bit sel_b, input logic [1:0] a, output logic [31:0] d);
        if (sel_b) ifb.address = a;
        else       ifa.address = a;
        @(negedge clk);
        d = sel_b ? ifb.readdata : ifa.readdata;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        apply_reset();
        tests_run++;
        if (ifa.readdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_readdata: got %h expected %h", ifa.readdata, 32'h0);
        end
        tests_run++;
        if (out_a !== 8'h00) begin
            tests_failed++; $display("FAIL reset_out_port: got %h expected %h", out_a, 8'h00);
        end
        tests_run++;
        if (fault_a !== 1'b0) begin
            tests_failed++; $display("FAIL reset_fault: got %b expected %b", fault_a, 1'b0);
        end
        bus_read(1'b0, 2'd3, rd);
        tests_run++;
        if (rd !== 32'd50000000) begin
            tests_failed++; $display("FAIL reset_wd_cnt: got %0d expected %0d", rd, 50000000);
        end
    endtask

    task automatic test_data_rw();
        logic [31:0] rd;
        bus_write(1'b0, 2'd0, 32'h0000_00A5);
        bus_write(1'b0, 2'd1, 32'h0000_0002);
        bus_write(1'b0, 2'd2, 32'h0000_0081);
        bus_read(1'b0, 2'd0, rd);
        tests_run++;
        if (rd !== 32'h26) begin
            tests_failed++; $display("FAIL data_read: got %h expected %h", rd, 32'h26);
        end
        tests_run++;
        if (out_a !== 8'h26) begin
            tests_failed++; $display("FAIL data_out_port: got %h expected %h", out_a, 8'h26);
        end
        bus_read(1'b0, 2'd2, rd);
        tests_run++;
        if (rd !== 32'h26) begin
            tests_failed++; $display("FAIL out_port_read: got %h expected %h", rd, 32'h26);
        end
        // Changing the address must not alter readdata before the next edge.
        ifa.address = 2'd1;
        #1;
        tests_run++;
        if (ifa.readdata !== 32'h26) begin
            tests_failed++; $display("FAIL read_latency: got %h expected %h", ifa.readdata, 32'h26);
        end
        @(negedge clk);
    endtask

    task automatic test_estop();
        logic [31:0] rd;
        estop_a = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_a !== 8'h26) begin
            tests_failed++; $display("FAIL estop_edge2_out: got %h expected %h", out_a, 8'h26);
        end
        @(negedge clk);
        tests_run++;
        if (out_a !== 8'h00) begin
            tests_failed++; $display("FAIL estop_edge3_out: got %h expected %h", out_a, 8'h00);
        end
        bus_read(1'b0, 2'd1, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++; $display("FAIL estop_status: got %h expected %h", rd, 32'h3);
        end
        bus_write(1'b0, 2'd3, 32'h2);
        tests_run++;
        if (fault_a !== 1'b1) begin
            tests_failed++; $display("FAIL estop_fclr_blocked: got %b expected %b", fault_a, 1'b1);
        end
        estop_a = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (fault_a !== 1'b1) begin
            tests_failed++; $display("FAIL estop_fault_latched: got %b expected %b", fault_a, 1'b1);
        end
        bus_write(1'b0, 2'd3, 32'h2);
        tests_run++;
        if (out_a !== 8'h26) begin
            tests_failed++; $display("FAIL estop_recover_out: got %h expected %h", out_a, 8'h26);
        end
        bus_read(1'b0, 2'd1, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++; $display("FAIL estop_status_clear: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] rd;
        apply_reset();
        repeat (15) @(negedge clk);
        tests_run++;
        if (fault_b !== 1'b0) begin
            tests_failed++; $display("FAIL wd_before_expire: got %b expected %b", fault_b, 1'b0);
        end
        @(negedge clk);
        tests_run++;
        if (fault_b !== 1'b1) begin
            tests_failed++; $display("FAIL wd_expire_fault: got %b expected %b", fault_b, 1'b1);
        end
        bus_read(1'b1, 2'd1, rd);
        tests_run++;
        if (rd !== 32'h5) begin
            tests_failed++; $display("FAIL wd_status: got %h expected %h", rd, 32'h5);
        end
        bus_write(1'b1, 2'd3, 32'h1);
        bus_read(1'b1, 2'd3, rd);
        tests_run++;
        if (rd !== 32'd16) begin
            tests_failed++; $display("FAIL wd_kick_reload: got %0d expected %0d", rd, 16);
        end
        tests_run++;
        if (fault_b !== 1'b1) begin
            tests_failed++; $display("FAIL wd_kick_keeps_fault: got %b expected %b", fault_b, 1'b1);
        end
        bus_write(1'b1, 2'd0, 32'h3C);
        tests_run++;
        if (out_b !== 8'h00) begin
            tests_failed++; $display("FAIL wd_write_while_fault: got %h expected %h", out_b, 8'h00);
        end
        bus_write(1'b1, 2'd3, 32'h3);
        tests_run++;
        if (out_b !== 8'h3C || fault_b !== 1'b0) begin
            tests_failed++; $display("FAIL wd_clear: got out=%h fault=%b expected out=%h fault=%b", out_b, fault_b, 8'h3C, 1'b0);
        end
        bus_read(1'b1, 2'd3, rd);
        bus_read(1'b1, 2'd3, rd);
        tests_run++;
        if (rd !== 32'd15) begin
            tests_failed++; $display("FAIL wd_runs_again: got %0d expected %0d", rd, 15);
        end
    endtask

    task automatic test_kick_boundary();
        logic [31:0] rd;
        apply_reset();
        repeat (15) @(negedge clk);
        bus_write(1'b1, 2'd3, 32'h1);
        tests_run++;
        if (fault_b !== 1'b0) begin
            tests_failed++; $display("FAIL kick_at_one_fault: got %b expected %b", fault_b, 1'b0);
        end
        bus_read(1'b1, 2'd3, rd);
        tests_run++;
        if (rd !== 32'd16) begin
            tests_failed++; $display("FAIL kick_at_one_cnt: got %0d expected %0d", rd, 16);
        end
        bus_read(1'b1, 2'd1, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++; $display("FAIL kick_at_one_status: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        apply_reset();
        bus_write(1'b1, 2'd0, 32'h81);
        repeat (15) @(negedge clk);
        bus_write(1'b1, 2'd3, 32'h1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (fault_b !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_precondition: got %b expected %b", fault_b, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (fault_b !== 1'b0 || out_b !== 8'h00 || ifb.readdata !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_async: got fault=%b out=%h rd=%h expected fault=0 out=00 rd=00000000", fault_b, out_b, ifb.readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(1'b1, 2'd3, rd);
        tests_run++;
        if (rd !== 32'd16) begin
            tests_failed++; $display("FAIL midrst_wd_cnt: got %0d expected %0d", rd, 16);
        end
        bus_read(1'b1, 2'd0, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_data: got %h expected %h", rd, 32'h0);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_n        = 1'b0;
        estop_a        = 1'b0;
        estop_b        = 1'b0;
        ifa.address    = '0; ifa.chipselect = 1'b0; ifa.write_n = 1'b1; ifa.writedata = '0;
        ifb.address    = '0; ifb.chipselect = 1'b0; ifb.write_n = 1'b1; ifb.writedata = '0;
        @(negedge clk);
        test_reset();
        test_data_rw();
        test_estop();
        test_watchdog();
        test_kick_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
